// File: rtl/weight_loader.sv
// Streams 2*2**ADDR words into two write-only RAM banks in order: bank 1 first, then bank 2.
// Write ports are registered (1-cycle latency); done holds until the next accepted start.
module weight_loader #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ADDR  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             we1,
    output logic [ADDR-1:0]  waddr1,
    output logic [WIDTH-1:0] wdata1,
    output logic             we2,
    output logic [ADDR-1:0]  waddr2,
    output logic [WIDTH-1:0] wdata2,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD1 = 2'd1,
        LOAD2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ADDR-1:0] cnt;
    logic            accept;
    logic            cnt_last;
    logic            start_ok;

    // Handshake and status are pure decodes of the state flop.
    assign s_ready  = (state == LOAD1) || (state == LOAD2);
    assign busy     = s_ready;
    assign done     = (state == DONE);
    assign accept   = s_valid && s_ready;
    assign cnt_last = (cnt == {ADDR{1'b1}});
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD1;
            LOAD1:   if (accept && cnt_last) state_nxt = LOAD2;
            LOAD2:   if (accept && cnt_last) state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD1;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared address counter; wraps naturally at the bank boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start_ok) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + ADDR'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we1    <= 1'b0;
            we2    <= 1'b0;
            waddr1 <= '0;
            wdata1 <= '0;
            waddr2 <= '0;
            wdata2 <= '0;
        end else begin
            we1 <= accept && (state == LOAD1);
            we2 <= accept && (state == LOAD2);
            if (accept && (state == LOAD1)) begin
                waddr1 <= cnt;
                wdata1 <= s_data;
            end
            if (accept && (state == LOAD2)) begin
                waddr2 <= cnt;
                wdata2 <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a word-count model predicts each write,
// and monitors compare the write ports against the predicted queue.
module tb_weight_loader;

    localparam int unsigned W  = 16;
    localparam int unsigned A  = 5;
    localparam int unsigned N  = 1 << A;
    localparam int unsigned SA = 2;
    localparam int unsigned SN = 1 << SA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0, s_valid = 1'b0, s_ready, busy, done;
    logic [W-1:0] s_data = '0, wdata1, wdata2;
    logic         we1, we2;
    logic [A-1:0] waddr1, waddr2;

    logic          sm_start = 1'b0, sm_valid = 1'b0, sm_ready, sm_busy, sm_done;
    logic [W-1:0]  sm_data = '0, sm_wdata1, sm_wdata2;
    logic          sm_we1, sm_we2;
    logic [SA-1:0] sm_waddr1, sm_waddr2;

    weight_loader #(.WIDTH(W), .ADDR(A)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .we2(we2), .waddr2(waddr2), .wdata2(wdata2), .busy(busy), .done(done)
    );

    weight_loader #(.WIDTH(W), .ADDR(SA)) u_small (
        .clk(clk), .rst_n(rst_n), .start(sm_start), .s_valid(sm_valid), .s_data(sm_data),
        .s_ready(sm_ready), .we1(sm_we1), .waddr1(sm_waddr1), .wdata1(sm_wdata1),
        .we2(sm_we2), .waddr2(sm_waddr2), .wdata2(sm_wdata2), .busy(sm_busy), .done(sm_done)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Expected write: {bank2, addr[4:0], data[15:0]}
    logic [21:0] q[$];
    logic [21:0] q2[$];
    logic [W-1:0] img1[N];
    logic [W-1:0] img2[N];
    logic [W-1:0] stream[2*N];

    bit m_load = 1'b0;
    bit m_done = 1'b0;
    int m_idx  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Main-DUT monitor: every strobe must match the head of the queue.
    always @(posedge clk) begin
        logic [21:0] e;
        #1;
        if (we1 && we2) begin
            chk("both_strobes", 32'(1), 32'(0));
        end else if (we1 || we2) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 32'(1), 32'(0));
            end else begin
                e = q.pop_front();
                chk("wr_bank", 32'(we2), 32'(e[21]));
                chk("wr_addr", 32'(we2 ? waddr2 : waddr1), 32'(e[20:16]));
                chk("wr_data", 32'(we2 ? wdata2 : wdata1), 32'(e[15:0]));
                if (we1) img1[waddr1] = wdata1;
                else     img2[waddr2] = wdata2;
            end
        end
    end

    // Small-DUT monitor.
    always @(posedge clk) begin
        logic [21:0] e;
        #1;
        if (sm_we1 && sm_we2) begin
            chk("sm_both_strobes", 32'(1), 32'(0));
        end else if (sm_we1 || sm_we2) begin
            if (q2.size() == 0) begin
                chk("sm_unexpected_write", 32'(1), 32'(0));
            end else begin
                e = q2.pop_front();
                chk("sm_wr_bank", 32'(sm_we2), 32'(e[21]));
                chk("sm_wr_addr", 32'(sm_we2 ? sm_waddr2 : sm_waddr1), 32'(e[20:16]));
                chk("sm_wr_data", 32'(sm_we2 ? sm_wdata2 : sm_wdata1), 32'(e[15:0]));
            end
        end
    end

    // One cycle: check status against the model, drive inputs, advance the model.
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit st);
        @(negedge clk);
        chk("s_ready", 32'(s_ready), 32'(m_load));
        chk("busy", 32'(busy), 32'(m_load));
        chk("done", 32'(done), 32'(m_done));
        start   = st;
        s_valid = v;
        s_data  = d;
        if (v && m_load) begin
            q.push_back({(m_idx >= int'(N)), 5'(m_idx % int'(N)), d});
            stream[m_idx] = d;
            m_idx++;
            if (m_idx == int'(2 * N)) begin
                m_load = 1'b0;
                m_done = 1'b1;
            end
        end else if (st && !m_load) begin
            m_load = 1'b1;
            m_done = 1'b0;
            m_idx  = 0;
        end
    endtask

    task automatic clear_imgs();
        for (int i = 0; i < int'(N); i++) begin
            img1[i] = 'x;
            img2[i] = 'x;
        end
    endtask

    task automatic check_imgs(input string name);
        int bad = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (img1[i] !== stream[i]) bad++;
            if (img2[i] !== stream[int'(N) + i]) bad++;
        end
        chk(name, 32'(bad), 32'(0));
    endtask

    // Random-gap load with a cycle budget; optional ignored start pulses.
    task automatic rand_load(input string name, input bit pulse_start);
        int n = 0;
        clear_imgs();
        cyc(1'b0, '0, 1'b1);
        while (!m_done && n < 2000) begin
            bit v = ($urandom_range(0, 99) >= 40);
            bit st = pulse_start && v && (m_idx == 10 || m_idx == 40);
            cyc(v, W'($urandom), st);
            n++;
        end
        chk({name, "_timeout"}, 32'(m_done), 32'(1));
        cyc(1'b0, '0, 1'b0);
        check_imgs({name, "_image"});
    endtask

    initial begin
        clear_imgs();
        // Reset values.
        #12;
        chk("rst_s_ready", 32'(s_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_we", 32'({we1, we2}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Full back-to-back load of 0..63, start in cycle 3.
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        for (int i = 0; i < int'(2 * N); i++) cyc(1'b1, W'(i), 1'b0);
        cyc(1'b0, '0, 1'b0);
        check_imgs("seq_image");

        // After DONE: valid without start writes nothing, done holds.
        for (int i = 0; i < 5; i++) cyc(1'b1, W'(16'hbeef + i), 1'b0);

        // Restart from DONE with random gaps.
        rand_load("gap", 1'b0);
        // Start pulses mid-load are ignored.
        rand_load("pulse", 1'b1);

        // Async reset mid-cycle after beat 20 of bank 1.
        cyc(1'b0, '0, 1'b1);
        while (m_idx < 21) cyc(1'b1, W'($urandom), 1'b0);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("arst_outputs", 32'({s_ready, we1, we2, busy, done}), 32'(0));
        chk("arst_addr", 32'({waddr1, waddr2}), 32'(0));
        chk("arst_data", 32'({wdata1, wdata2}), 32'(0));
        m_load = 1'b0;
        m_done = 1'b0;
        m_idx  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b0);
        rand_load("post_rst", 1'b0);

        // ADDR=2 instance: 8-word back-to-back load.
        @(negedge clk);
        sm_start = 1'b1;
        @(negedge clk);
        sm_start = 1'b0;
        for (int i = 0; i < int'(2 * SN); i++) begin
            chk("sm_ready", 32'(sm_ready), 32'(1));
            sm_valid = 1'b1;
            sm_data  = W'(16'h100 + i);
            q2.push_back({(i >= int'(SN)), 5'(i % int'(SN)), W'(16'h100 + i)});
            @(negedge clk);
        end
        sm_valid = 1'b0;
        chk("sm_done", 32'(sm_done), 32'(1));
        chk("sm_ready_end", 32'(sm_ready), 32'(0));
        chk("sm_busy_end", 32'(sm_busy), 32'(0));
        repeat (3) @(negedge clk);

        chk("q_drained", 32'(q.size()), 32'(0));
        chk("q2_drained", 32'(q2.size()), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
